// File: rtl/sd_join2_if.sv
// Srdy/drdy handshake bundle: srdy/data flow master->slave, drdy flows back.
// A transfer happens on any rising clk edge where srdy & drdy are both high.
interface sd_join2_if #(
   parameter int width = 8
);
   logic             srdy;
   logic             drdy;
   logic [width-1:0] data;

   modport master (output srdy, output data, input drdy);
   modport slave  (input srdy, input data, output drdy);
endinterface

// File: rtl/sd_join2.sv
// 2:1 srdy/drdy joiner: pairs two consecutive half-width tokens into one
// registered full-width token. First half lands in the MSBs when msb_first=1.
module sd_join2 #(
   parameter int width     = 8,
   parameter bit msb_first = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   sd_join2_if.slave    c,
   sd_join2_if.master   p,
   output logic         state_dbg
);

   localparam int half = width / 2;

   typedef enum logic {
      S_FIRST  = 1'b0,
      S_SECOND = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [half-1:0]   hold;
   logic [width-1:0]  p_data_r;
   logic [width-1:0]  joined;
   logic              p_srdy_r;
   logic              c_drdy_w;
   logic              accept;
   logic              hold_en;
   logic              load;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_FIRST;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_FIRST:  if (accept) state_nxt = S_SECOND;
         S_SECOND: if (accept) state_nxt = S_FIRST;
         default:  state_nxt = S_FIRST;
      endcase
   end

   // Output logic; the p.drdy -> c.drdy path in S_SECOND is combinational on purpose
   always_comb begin
      c_drdy_w = 1'b1;
      hold_en  = 1'b0;
      load     = 1'b0;
      case (state)
         S_FIRST: begin
            c_drdy_w = 1'b1;
            hold_en  = c.srdy;
         end
         S_SECOND: begin
            c_drdy_w = ~p_srdy_r | p.drdy;
            load     = c.srdy & c_drdy_w;
         end
         default: begin
            c_drdy_w = 1'b1;
         end
      endcase
   end

   assign accept = c.srdy & c_drdy_w;

   always_comb begin
      if (msb_first) joined = {hold, c.data};
      else           joined = {c.data, hold};
   end

   // Hold and output data are not reset; p_data is meaningless while p_srdy=0
   always_ff @(posedge clk) begin
      if (hold_en) hold <= c.data;
      if (load)    p_data_r <= joined;
   end

   always_ff @(posedge clk) begin
      if (reset)       p_srdy_r <= 1'b0;
      else if (load)   p_srdy_r <= 1'b1;
      else if (p.drdy) p_srdy_r <= 1'b0;
   end

   assign c.drdy    = c_drdy_w;
   assign p.srdy    = p_srdy_r;
   assign p.data    = p_data_r;
   assign state_dbg = (state == S_SECOND);

endmodule
